// File: rtl/ddi_phase_sequencer_pkg.sv
// rtl/ddi_phase_sequencer_pkg.sv - shared encodings for the DDI phase sequencer
package ddi_phase_sequencer_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } interval_e;

  localparam int PHASE_1   = 0;
  localparam int PHASE_2   = 1;
  localparam int PRIO_BASE = 2;

  // Pointer width stays at least 1 bit so a single-approach build still has a port.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddi_rr_arbiter.sv
// rtl/ddi_rr_arbiter.sv - combinational round-robin picker over pending priority requests
module ddi_rr_arbiter
  import ddi_phase_sequencer_pkg::*;
#(
  parameter  int NUM_PRIO = 2,
  localparam int PTR_W    = ptr_width(NUM_PRIO)
) (
  input  logic [NUM_PRIO-1:0] pending,
  input  logic [PTR_W-1:0]    ptr,
  output logic [NUM_PRIO-1:0] grant,
  output logic [PTR_W-1:0]    grant_idx,
  output logic                valid
);

  logic [PTR_W-1:0] idx;

  // First pending bit at or above ptr, wrapping; later hits are ignored once valid.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_PRIO; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_PRIO);
      if (!valid && pending[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/ddi_phase_sequencer.sv
// rtl/ddi_phase_sequencer.sv - timed GREEN/YELLOW/ALLRED phase sequencer with round-robin priority phases
module ddi_phase_sequencer
  import ddi_phase_sequencer_pkg::*;
#(
  parameter  int NUM_PRIO = 2,
  parameter  int CNT_W    = 16,
  localparam int PHASE_W  = $clog2(NUM_PRIO + 2)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                hold,
  input  logic [CNT_W-1:0]    green_len,
  input  logic [CNT_W-1:0]    prio_green_len,
  input  logic [CNT_W-1:0]    yellow_len,
  input  logic [CNT_W-1:0]    allred_len,
  input  logic [NUM_PRIO-1:0] prio_req,
  output logic [PHASE_W-1:0]  phase,
  output logic [1:0]          interval,
  output logic                phase_start,
  output logic [NUM_PRIO-1:0] prio_grant,
  output logic [NUM_PRIO-1:0] prio_pending
);

  localparam int PTR_W = ptr_width(NUM_PRIO);

  logic [PHASE_W-1:0]  phase_q, phase_d;
  interval_e           interval_q, interval_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_PRIO-1:0] pending_q, pending_d;
  logic [NUM_PRIO-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                start_q, start_d;
  logic                init_q, init_d;

  logic [NUM_PRIO-1:0] arb_grant;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [PTR_W-1:0]    rr_next;
  logic [NUM_PRIO-1:0] clr;
  logic                expire;

  ddi_rr_arbiter #(
    .NUM_PRIO (NUM_PRIO)
  ) u_arb (
    .pending   (pending_q),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  // A zero length still occupies one tick.
  function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  assign rr_next = (arb_idx == PTR_W'(NUM_PRIO - 1)) ? '0 : arb_idx + 1'b1;
  assign expire  = tick && (count_q == '0) && !(interval_q == GREEN && hold);

  always_comb begin
    phase_d    = phase_q;
    interval_d = interval_q;
    count_d    = count_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    start_d    = 1'b0;
    init_d     = init_q;
    clr        = '0;

    if (tick && count_q != '0) begin
      count_d = count_q - 1'b1;
    end

    if (expire) begin
      case (interval_q)
        GREEN: begin
          interval_d = YELLOW;
          count_d    = load_cnt(yellow_len);
        end
        YELLOW: begin
          interval_d = ALLRED;
          count_d    = load_cnt(allred_len);
        end
        default: begin
          interval_d = GREEN;
          start_d    = 1'b1;
          init_d     = 1'b0;
          // The reset ALLRED always hands over to PHASE_1, whatever phase reads.
          if (!init_q && phase_q == PHASE_W'(PHASE_2) && arb_valid) begin
            phase_d  = PHASE_W'(PRIO_BASE) + PHASE_W'(arb_idx);
            grant_d  = arb_grant;
            clr      = arb_grant;
            rr_ptr_d = rr_next;
            count_d  = load_cnt(prio_green_len);
          end else begin
            phase_d  = (!init_q && phase_q == PHASE_W'(PHASE_1)) ? PHASE_W'(PHASE_2)
                                                                 : PHASE_W'(PHASE_1);
            grant_d  = '0;
            count_d  = load_cnt(green_len);
          end
        end
      endcase
    end

    // Set dominates clear so a held level request re-arms immediately.
    pending_d = (pending_q & ~clr) | prio_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PHASE_W'(PHASE_1);
      interval_q <= ALLRED;
      count_q    <= '0;
      pending_q  <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      start_q    <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      phase_q    <= phase_d;
      interval_q <= interval_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      start_q    <= start_d;
      init_q     <= init_d;
    end
  end

  assign phase        = phase_q;
  assign interval     = interval_q;
  assign phase_start  = start_q;
  assign prio_grant   = grant_q;
  assign prio_pending = pending_q;

endmodule

// File: tb/tb_ddi_phase_sequencer.sv
// tb/tb_ddi_phase_sequencer.sv - scoreboard bench for ddi_phase_sequencer
module tb_ddi_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        hold;
  logic [15:0] green_len, prio_green_len, yellow_len, allred_len;
  logic [1:0]  prio_req;
  logic [1:0]  phase;
  logic [1:0]  interval;
  logic        phase_start;
  logic [1:0]  prio_grant;
  logic [1:0]  prio_pending;

  int checks   = 0;
  int failures = 0;
  int tick_div = 1;
  int done_cnt = 0;

  typedef struct {
    int ph;
    int gr;
    int pd;
    int g;
    int y;
  } exp_t;

  exp_t expq[$];

  ddi_phase_sequencer #(
    .NUM_PRIO (2),
    .CNT_W    (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick           (tick),
    .hold           (hold),
    .green_len      (green_len),
    .prio_green_len (prio_green_len),
    .yellow_len     (yellow_len),
    .allred_len     (allred_len),
    .prio_req       (prio_req),
    .phase          (phase),
    .interval       (interval),
    .phase_start    (phase_start),
    .prio_grant     (prio_grant),
    .prio_pending   (prio_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int ph, input int gr, input int pd, input int g, input int y);
    exp_t e;
    e.ph = ph; e.gr = gr; e.pd = pd; e.g = g; e.y = y;
    expq.push_back(e);
  endtask

  initial begin
    int c;
    c    = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      tick = ((c % tick_div) == 0);
    end
  end

  // Monitor: pops one expectation per phase_start and measures GREEN/YELLOW in ticks.
  initial begin
    exp_t       cur;
    bit         in_rec;
    int         cnt;
    logic [1:0] p_int, p_ph;
    logic       p_tick, p_rst;
    in_rec = 0; cnt = 0; p_int = 2'd2; p_ph = 2'd0; p_tick = 1'b0; p_rst = 1'b0;
    cur.ph = 0; cur.gr = 0; cur.pd = 0; cur.g = 0; cur.y = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_rec = 0;
        cnt    = 0;
      end else begin
        if (p_rst && (interval != p_int || phase != p_ph)) chk("boundary_on_tick", int'(p_tick), 1);
        if (phase_start) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_phase_start actual_phase=%0d required=none", phase);
            in_rec = 0;
          end else begin
            cur    = expq.pop_front();
            in_rec = 1;
            chk("start_phase", int'(phase), cur.ph);
            chk("start_grant", int'(prio_grant), cur.gr);
            chk("start_pending", int'(prio_pending), cur.pd);
            chk("start_interval", int'(interval), 0);
          end
          cnt = 0;
        end else if (in_rec && interval != p_int) begin
          if (p_int == 2'd0) begin
            chk("green_ticks", cnt, cur.g);
          end else if (p_int == 2'd1) begin
            chk("yellow_ticks", cnt, cur.y);
            done_cnt++;
            in_rec = 0;
          end
          cnt = 0;
        end
        cnt += int'(tick);
      end
      p_int = interval; p_ph = phase; p_tick = tick; p_rst = rst_n;
    end
  end

  task automatic begin_test(input int g);
    #1;
    rst_n     = 1'b0;
    prio_req  = 2'b00;
    hold      = 1'b0;
    green_len = 16'(g);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_interval", int'(interval), 2);
    chk("rst_start", int'(phase_start), 0);
    chk("rst_grant", int'(prio_grant), 0);
    chk("rst_pending", int'(prio_pending), 0);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("records_done", done_cnt, target);
    chk("queue_drained", expq.size(), 0);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!phase_start && n < 500);
    chk("phase_start_seen", int'(phase_start), 1);
  endtask

  initial begin
    int base;
    int n;
    rst_n          = 1'b0;
    hold           = 1'b0;
    prio_req       = 2'b00;
    green_len      = 16'd3;
    prio_green_len = 16'd2;
    yellow_len     = 16'd2;
    allred_len     = 16'd1;

    // Plain P1/P2 cycling.
    begin_test(3);
    base = done_cnt;
    push(0, 0, 0, 3, 2); push(1, 0, 0, 3, 2); push(0, 0, 0, 3, 2);
    rst_n = 1'b1;
    wait_done(base + 3);

    // Single priority request on approach 1.
    begin_test(3);
    base = done_cnt;
    push(0, 0, 0, 3, 2); push(1, 0, 2, 3, 2); push(3, 2, 0, 2, 2); push(0, 0, 0, 3, 2);
    rst_n = 1'b1;
    wait_start();
    @(posedge clk); #1 prio_req = 2'b10;
    @(posedge clk); #1 prio_req = 2'b00;
    wait_done(base + 4);

    // Simultaneous requests are served in turn.
    begin_test(3);
    base = done_cnt;
    push(0, 0, 0, 3, 2); push(1, 0, 3, 3, 2); push(2, 1, 2, 2, 2); push(0, 0, 2, 3, 2);
    push(1, 0, 2, 3, 2); push(3, 2, 0, 2, 2); push(0, 0, 0, 3, 2);
    rst_n = 1'b1;
    wait_start();
    @(posedge clk); #1 prio_req = 2'b11;
    @(posedge clk); #1 prio_req = 2'b00;
    wait_done(base + 7);

    // Hold extends GREEN; YELLOW follows one tick after release.
    begin_test(2);
    base = done_cnt;
    hold = 1'b1;
    push(0, 0, 0, 11, 2); push(1, 0, 0, 2, 2); push(0, 0, 0, 2, 2);
    rst_n = 1'b1;
    wait_start();
    repeat (10) @(posedge clk);
    #1 hold = 1'b0;
    wait_done(base + 3);

    // Sparse timebase: one tick every fourth cycle.
    tick_div = 4;
    begin_test(2);
    base = done_cnt;
    push(0, 0, 0, 2, 2); push(1, 0, 0, 2, 2); push(0, 0, 0, 2, 2);
    rst_n = 1'b1;
    wait_done(base + 3);
    tick_div = 1;

    // Length changed mid-GREEN applies only from the next entry.
    begin_test(5);
    base = done_cnt;
    push(0, 0, 0, 5, 2); push(1, 0, 0, 1, 2); push(0, 0, 0, 1, 2);
    rst_n = 1'b1;
    wait_start();
    @(posedge clk); #1 green_len = 16'd1;
    wait_done(base + 3);

    // Asynchronous reset in the middle of a priority phase.
    begin_test(3);
    push(0, 0, 0, 3, 2); push(1, 0, 1, 3, 2); push(2, 1, 0, 2, 2);
    rst_n = 1'b1;
    wait_start();
    @(posedge clk); #1 prio_req = 2'b01;
    @(posedge clk); #1 prio_req = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(phase == 2'd2 && interval == 2'd1) && n < 500);
    chk("prio_yellow_reached", int'(phase == 2'd2 && interval == 2'd1), 1);
    @(posedge clk); #1 prio_req = 2'b10;
    @(posedge clk); #1 prio_req = 2'b00;
    chk("pre_rst_phase", int'(phase), 2);
    chk("pre_rst_interval", int'(interval), 2);
    chk("pre_rst_grant", int'(prio_grant), 1);
    chk("pre_rst_pending", int'(prio_pending), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_phase", int'(phase), 0);
    chk("async_rst_interval", int'(interval), 2);
    chk("async_rst_grant", int'(prio_grant), 0);
    chk("async_rst_pending", int'(prio_pending), 0);
    chk("async_rst_start", int'(phase_start), 0);
    repeat (3) @(posedge clk);
    chk("final_queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
